// File: rtl/pipe_memory_pkg.sv
// Shared types and constants for the memory-request pipe stage.
// States, fault codes and funct3 width encodings.
package pipe_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUS     = 2'b01,
    RESPOND = 2'b10,
    FAULT   = 2'b11
  } memState_t;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
  localparam logic [1:0] FAULT_FUNCT3     = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT    = 2'b11;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

endpackage

// File: rtl/pipe_memory_request_align.sv
// Access decode: byte lanes, replicated store data,
// alignment and funct3 legality for one load/store.
module mem_access_align
  import pipe_memory_pkg::*;
(
  input  logic        isLoad,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [3:0]  byteSelect,
  output logic [31:0] writeData,
  output logic        misaligned,
  output logic        badFunct3
);

  // Decode width into lanes/data, then flag illegal encodings.
  always_comb begin
    byteSelect = 4'b0000;
    writeData  = 32'h0;
    misaligned = 1'b0;
    badFunct3  = 1'b0;
    unique case (1'b1)
      (funct3[1:0] == WIDTH_BYTE): begin
        byteSelect = 4'b0001 << address[1:0];
        writeData  = {4{storeData[7:0]}};
      end
      (funct3[1:0] == WIDTH_HALF): begin
        byteSelect = 4'b0011 << address[1:0];
        writeData  = {2{storeData[15:0]}};
        misaligned = address[0];
      end
      (funct3[1:0] == WIDTH_WORD): begin
        byteSelect = 4'b1111;
        writeData  = storeData;
        misaligned = |address[1:0];
      end
      default: badFunct3 = 1'b1;
    endcase
    // Unsigned variants exist only for byte/half loads.
    if (funct3[2] && (!isLoad || funct3[1]))
      badFunct3 = 1'b1;
  end

endmodule

// File: rtl/pipe_memory_request.sv
// Memory pipe stage bus initiator: one load/store per request/ack.
// Optional MEM_TIMEOUT_EN faults a bus cycle left unacked too long.
module pipe_memory_request
  import pipe_memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        requestValid,
  input  logic        requestLoad,
  input  logic [2:0]  requestFunct3,
  input  logic [31:0] requestAddress,
  input  logic [31:0] requestStoreData,
  output logic        requestReady,
  output logic        requestStall,
  output logic        responseValid,
  output logic [31:0] responseData,
  output logic        responseFault,
  output logic [1:0]  responseFaultCode,
  output logic        memRequest,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [3:0]  memByteSelect,
  output logic [31:0] memWriteData,
  input  logic        memAck,
  input  logic [31:0] memDataRead
);

  memState_t   state;
  memState_t   stateNext;
  logic        accept;
  logic        acceptFault;
  logic [1:0]  acceptCode;
  logic [3:0]  alignSel;
  logic [31:0] alignData;
  logic        misaligned;
  logic        badFunct3;
  logic        isLoadReg;
  logic        writeReg;
  logic [1:0]  faultCode;
  logic        busAck;
  logic        timeoutHit;

  mem_access_align uAlign (
    .isLoad     (requestLoad),
    .funct3     (requestFunct3),
    .address    (requestAddress),
    .storeData  (requestStoreData),
    .byteSelect (alignSel),
    .writeData  (alignData),
    .misaligned (misaligned),
    .badFunct3  (badFunct3)
  );

  assign requestReady = (state == IDLE) || (state == RESPOND);
  assign accept       = requestValid && requestReady;
  assign acceptCode   = badFunct3  ? FAULT_FUNCT3 :
                        misaligned ? FAULT_MISALIGNED : FAULT_NONE;
  assign acceptFault  = (acceptCode != FAULT_NONE);
  assign busAck       = (state == BUS) && memAck;

  assign requestStall = (requestValid && (state == IDLE)) || (state == BUS);
  assign memRequest   = (state == BUS);
  assign memWriteEnable    = writeReg && (state == BUS);
  assign responseValid     = (state == RESPOND) || (state == FAULT);
  assign responseFault     = (state == FAULT);
  assign responseFaultCode = (state == FAULT) ? faultCode : FAULT_NONE;

`ifdef MEM_TIMEOUT_EN
  localparam int CountWidth =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CountWidth-1:0] timeoutCount;

  // Count unacked BUS cycles; held at zero outside BUS.
  always_ff @(posedge clk) begin
    if (rst || state != BUS)
      timeoutCount <= '0;
    else if (!memAck)
      timeoutCount <= timeoutCount + 1'b1;
  end

  assign timeoutHit = (state == BUS) && !memAck &&
    (timeoutCount == CountWidth'(TIMEOUT_CYCLES - 1));
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timeoutHit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // Next-state: ack beats timeout; RESPOND can chain a new access.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, RESPOND: begin
        if (accept)
          stateNext = acceptFault ? FAULT : BUS;
        else
          stateNext = IDLE;
      end
      BUS: begin
        if (memAck)
          stateNext = RESPOND;
        else if (timeoutHit)
          stateNext = FAULT;
      end
      FAULT:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture the access at accept and the read word at ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      memAddress    <= 32'h0;
      memByteSelect <= 4'b0000;
      memWriteData  <= 32'h0;
      writeReg      <= 1'b0;
      isLoadReg     <= 1'b0;
      faultCode     <= FAULT_NONE;
      responseData  <= 32'h0;
    end else begin
      if (accept) begin
        memAddress    <= {requestAddress[31:2], 2'b00};
        memByteSelect <= alignSel;
        memWriteData  <= alignData;
        writeReg      <= !requestLoad;
        isLoadReg     <= requestLoad;
        faultCode     <= acceptCode;
        if (acceptFault)
          responseData <= 32'h0;
      end
      if (busAck)
        responseData <= isLoadReg ? memDataRead : 32'h0;
      else if (timeoutHit) begin
        faultCode    <= FAULT_TIMEOUT;
        responseData <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_memory_request.sv
// Directed bench for pipe_memory_request: vector table
// plus back-to-back, reset-mid-bus and timeout sequences.
module tb_pipe_memory_request;

  logic        clk;
  logic        rst;
  logic        requestValid;
  logic        requestLoad;
  logic [2:0]  requestFunct3;
  logic [31:0] requestAddress;
  logic [31:0] requestStoreData;
  logic        requestReady;
  logic        requestStall;
  logic        responseValid;
  logic [31:0] responseData;
  logic        responseFault;
  logic [1:0]  responseFaultCode;
  logic        memRequest;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [3:0]  memByteSelect;
  logic [31:0] memWriteData;
  logic        memAck;
  logic [31:0] memDataRead;

  int checks;
  int failures;

  typedef struct {
    logic        load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    logic [31:0] rd;
    logic [31:0] expAddr;
    logic [3:0]  expSel;
    logic [31:0] expWd;
    logic        expWe;
    logic [1:0]  expCode;
    logic [31:0] expResp;
  } vec_t;

  vec_t vecs [9];

  pipe_memory_request #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .requestValid      (requestValid),
    .requestLoad       (requestLoad),
    .requestFunct3     (requestFunct3),
    .requestAddress    (requestAddress),
    .requestStoreData  (requestStoreData),
    .requestReady      (requestReady),
    .requestStall      (requestStall),
    .responseValid     (responseValid),
    .responseData      (responseData),
    .responseFault     (responseFault),
    .responseFaultCode (responseFaultCode),
    .memRequest        (memRequest),
    .memWriteEnable    (memWriteEnable),
    .memAddress        (memAddress),
    .memByteSelect     (memByteSelect),
    .memWriteData      (memWriteData),
    .memAck            (memAck),
    .memDataRead       (memDataRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic drive(input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    requestValid     = 1'b1;
    requestLoad      = ld;
    requestFunct3    = f3;
    requestAddress   = a;
    requestStoreData = d;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.load, v.f3, v.addr, v.data);
    #1;
    check({tag, ".ready"}, 32'(requestReady), 32'd1);
    check({tag, ".stallAcc"}, 32'(requestStall), 32'd1);
    @(negedge clk);
    requestValid = 1'b0;
    #1;
    if (v.expCode != 2'b00) begin
      check({tag, ".noReq"}, 32'(memRequest), 32'd0);
      check({tag, ".fValid"}, 32'(responseValid), 32'd1);
      check({tag, ".fault"}, 32'(responseFault), 32'd1);
      check({tag, ".code"}, 32'(responseFaultCode), 32'(v.expCode));
      check({tag, ".fStall"}, 32'(requestStall), 32'd0);
      @(negedge clk);
      #1;
      check({tag, ".fDone"}, 32'(responseValid), 32'd0);
      check({tag, ".fNoReq"}, 32'(memRequest), 32'd0);
    end else begin
      for (int k = 0; k <= v.delay; k++) begin
        check({tag, ".req"}, 32'(memRequest), 32'd1);
        check({tag, ".addr"}, memAddress, v.expAddr);
        check({tag, ".sel"}, 32'(memByteSelect), 32'(v.expSel));
        check({tag, ".wd"}, memWriteData, v.expWd);
        check({tag, ".we"}, 32'(memWriteEnable), 32'(v.expWe));
        check({tag, ".stallBus"}, 32'(requestStall), 32'd1);
        check({tag, ".noResp"}, 32'(responseValid), 32'd0);
        if (k == v.delay) begin
          memAck      = 1'b1;
          memDataRead = v.rd;
        end
        @(negedge clk);
        memAck      = 1'b0;
        memDataRead = 32'h0;
        #1;
      end
      check({tag, ".reqDrop"}, 32'(memRequest), 32'd0);
      check({tag, ".rValid"}, 32'(responseValid), 32'd1);
      check({tag, ".rFault"}, 32'(responseFault), 32'd0);
      check({tag, ".rCode"}, 32'(responseFaultCode), 32'd0);
      check({tag, ".rData"}, responseData, v.expResp);
      check({tag, ".rStall"}, 32'(requestStall), 32'd0);
      @(negedge clk);
      #1;
      check({tag, ".rDone"}, 32'(responseValid), 32'd0);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    requestValid     = 1'b0;
    requestLoad      = 1'b0;
    requestFunct3    = 3'b000;
    requestAddress   = 32'h0;
    requestStoreData = 32'h0;
    memAck           = 1'b0;
    memDataRead      = 32'h0;

    vecs[0] = '{1'b1, 3'b010, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF,
                32'h0000_1004, 4'b1111, 32'h0, 1'b0, 2'b00,
                32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 3'b000, 32'h0000_2003, 32'h1234_56A5, 3,
                32'h1111_1111, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5,
                1'b1, 2'b00, 32'h0};
    vecs[2] = '{1'b1, 3'b001, 32'h0000_3001, 32'h0, 0, 32'h0, 32'h0,
                4'b0000, 32'h0, 1'b0, 2'b01, 32'h0};
    vecs[3] = '{1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'b0000,
                32'h0, 1'b0, 2'b10, 32'h0};
    vecs[4] = '{1'b0, 3'b001, 32'h4000_0002, 32'h0000_BEEF, 1,
                32'h2222_2222, 32'h4000_0000, 4'b1100, 32'hBEEF_BEEF,
                1'b1, 2'b00, 32'h0};
    vecs[5] = '{1'b1, 3'b100, 32'h0000_5001, 32'hFFFF_FFFF, 0,
                32'h1234_5678, 32'h0000_5000, 4'b0010, 32'hFFFF_FFFF,
                1'b0, 2'b00, 32'h1234_5678};
    vecs[6] = '{1'b1, 3'b110, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'b0000,
                32'h0, 1'b0, 2'b10, 32'h0};
    vecs[7] = '{1'b1, 3'b010, 32'h0000_6002, 32'h0, 0, 32'h0, 32'h0,
                4'b0000, 32'h0, 1'b0, 2'b01, 32'h0};
    vecs[8] = '{1'b0, 3'b101, 32'h0000_7003, 32'h0, 0, 32'h0, 32'h0,
                4'b0000, 32'h0, 1'b0, 2'b10, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready", 32'(requestReady), 32'd1);
    check("rst.stall", 32'(requestStall), 32'd0);
    check("rst.req", 32'(memRequest), 32'd0);
    check("rst.valid", 32'(responseValid), 32'd0);
    check("rst.fault", 32'(responseFault), 32'd0);
    check("rst.data", responseData, 32'h0);
    check("rst.addr", memAddress, 32'h0);

    for (int i = 0; i < 9; i++)
      runVec(vecs[i], i);

    // Back-to-back: second load accepted in the RESPOND cycle.
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_0100, 32'h0);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_0200, 32'h0);
    memAck      = 1'b1;
    memDataRead = 32'hAAAA_5555;
    #1;
    check("b2b.req1", 32'(memRequest), 32'd1);
    check("b2b.addr1", memAddress, 32'h0000_0100);
    @(negedge clk);
    memAck      = 1'b0;
    memDataRead = 32'h0;
    #1;
    check("b2b.resp1", 32'(responseValid), 32'd1);
    check("b2b.data1", responseData, 32'hAAAA_5555);
    check("b2b.ready", 32'(requestReady), 32'd1);
    check("b2b.stall", 32'(requestStall), 32'd0);
    @(negedge clk);
    requestValid = 1'b0;
    memAck       = 1'b1;
    memDataRead  = 32'h5555_AAAA;
    #1;
    check("b2b.req2", 32'(memRequest), 32'd1);
    check("b2b.addr2", memAddress, 32'h0000_0200);
    check("b2b.noResp", 32'(responseValid), 32'd0);
    @(negedge clk);
    memAck      = 1'b0;
    memDataRead = 32'h0;
    #1;
    check("b2b.resp2", 32'(responseValid), 32'd1);
    check("b2b.data2", responseData, 32'h5555_AAAA);

    // Reset while a bus cycle is outstanding.
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_0300, 32'h0);
    @(negedge clk);
    requestValid = 1'b0;
    #1;
    check("rbus.req", 32'(memRequest), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rbus.reqDrop", 32'(memRequest), 32'd0);
    check("rbus.ready", 32'(requestReady), 32'd1);
    check("rbus.noResp", 32'(responseValid), 32'd0);
    memAck      = 1'b1;
    memDataRead = 32'h9999_9999;
    @(negedge clk);
    memAck      = 1'b0;
    memDataRead = 32'h0;
    #1;
    check("idleAck.noResp", 32'(responseValid), 32'd0);
    check("idleAck.noReq", 32'(memRequest), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Unacked bus cycle faults after four BUS cycles.
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_8000, 32'h0);
    @(negedge clk);
    requestValid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("to.req", 32'(memRequest), 32'd1);
      @(negedge clk);
      #1;
    end
    check("to.reqDrop", 32'(memRequest), 32'd0);
    check("to.valid", 32'(responseValid), 32'd1);
    check("to.fault", 32'(responseFault), 32'd1);
    check("to.code", 32'(responseFaultCode), 32'd3);
    memAck      = 1'b1;
    memDataRead = 32'h7777_7777;
    @(negedge clk);
    #1;
    check("to.lateAck", 32'(responseValid), 32'd0);
    @(negedge clk);
    memAck = 1'b0;
    #1;
    check("to.lateAck2", 32'(responseValid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_memory_request.md
Name: pipe_memory_request

Overview:
Issues the load/store bus transaction for the memory pipe stage; it is the initiator end of the interface whose returned read word the store stage consumes. Accepts one access from execute, checks alignment and width, and forms the word address, byte select and replicated write data. Runs a request/ack handshake to the data bus, stalls the pipe while the bus is busy, and returns the raw read word plus fault status.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for memAck before faulting (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
requestValid  in  1  execute presents a load/store this cycle
requestLoad  in  1  1=load, 0=store
requestFunct3  in  3  RISC-V funct3 (width/sign)
requestAddress  in  32  byte address (ALU result)
requestStoreData  in  32  rs2 value for stores
requestReady  out  1  block can accept a request this cycle
requestStall  out  1  pipe must hold
responseValid  out  1  one-cycle pulse: access complete
responseData  out  32  raw bus word (unshifted; store stage extracts/sign-extends)
responseFault  out  1  access faulted (valid with responseValid)
responseFaultCode  out  2  00 none, 01 misaligned, 10 bad funct3, 11 timeout
memRequest  out  1  bus cycle active
memWriteEnable  out  1  1=write
memAddress  out  32  word address, [1:0] always 0
memByteSelect  out  4  active byte lanes
memWriteData  out  32  lane-replicated store data
memAck  in  1  target completes cycle
memDataRead  in  32  read word, valid with memAck

Behaviour:
- States: IDLE, BUS, RESPOND, FAULT. Reset: state IDLE, all outputs 0 except requestReady=1.
- requestReady = state is IDLE or RESPOND. Accept = requestValid && requestReady.
- Width: funct3[1:0] 00 byte, 01 half, 10 word. Valid loads: 000,001,010,100,101. Valid stores: 000,001,010. Anything else -> bad funct3.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Bad funct3 has priority over misaligned.
- ByteSelect: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. WriteData: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d. All registered at accept.
- Accept, no fault -> BUS next cycle; memRequest=1. Addr/sel/data/writeEnable stable until the ack cycle.
- memAck is sampled only while memRequest=1. memAck may arrive in the first BUS cycle, giving minimum latency: accept T, memRequest T+1, responseValid T+2.
- BUS + memAck -> RESPOND. In the same edge: memRequest drops and memDataRead is registered into responseData. For stores, responseData = 0.
- Accept with fault -> FAULT next cycle; no bus cycle is issued. FAULT lasts one cycle: responseValid=1, responseFault=1, code set.
- RESPOND: responseValid=1 for one cycle. If a new accept occurs in the same cycle, go to BUS/FAULT; otherwise go to IDLE.
- requestStall = (requestValid && state==IDLE) || state==BUS. It is low in RESPOND and FAULT, so the pipe steps on the response cycle.
- requestValid while BUS is ignored; execute is stalled.
- memAck outside BUS is ignored.
- rst mid-BUS: memRequest=0 after the edge and the state returns to IDLE; the target must tolerate the abandoned cycle.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on entry to BUS and increments each BUS cycle without ack. When the count reaches TIMEOUT_CYCLES: memRequest drops, state -> FAULT with code 11, and a late memAck is ignored.
- Undefined: BUS waits indefinitely; code 11 is never produced; no counter logic.

Decomposition:
- Package pipe_memory_pkg holds: state enum; fault code constants (FAULT_NONE, FAULT_MISALIGNED, FAULT_FUNCT3, FAULT_TIMEOUT); funct3 width constants.
- Sub-module mem_access_align: combinational; funct3 + address + store data -> byteSelect, writeData, misaligned, badFunct3.
- The FSM and registers live in the top module.

Test Plan:
- Load word addr 0x1004, memAck on first BUS cycle with memDataRead 0xDEADBEEF:
  - memAddress 0x1004, sel 1111, memWriteEnable 0;
  - responseValid 2 cycles after accept, responseData 0xDEADBEEF;
  - stall high for exactly 2 cycles.
- Store byte 0xA5 (rs2 0x123456A5) to 0x2003, ack after 3 wait cycles:
  - memAddress 0x2000, sel 1000, data 0xA5A5A5A5;
  - request held stable 4 cycles; responseValid 1 cycle later, fault 0.
- Load half addr 0x3001: no memRequest; next cycle responseValid=1, fault=1, code 01, stall low.
- Store funct3 011 addr 0x0: code 10, no bus cycle.
- Back-to-back: second load accepted in RESPOND cycle; memRequest re-asserts the next cycle; no IDLE gap.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - memRequest drops after 4 BUS cycles; code 11;
  - memAck injected later causes no response.
- Reset during BUS: memRequest 0 next cycle, requestReady 1, no responseValid.
